// File: rtl/mmio_button_io.sv
`default_nettype none
// ============================================================================
// mmio_button_io : debounced button read port and 1-entry output buffer on
//                  the processor data bus.
// Revision 1.0
// ============================================================================
module mmio_button_io #(
  parameter int NUM_BTNS        = 5,
  parameter int BTN_BASE        = 1000,
  parameter int BTN_STRIDE      = 1000,
  parameter int OUT_ADDR        = 2000,
  parameter int STATUS_ADDR     = 7000,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int EVENT_MODE      = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [31:0]         address_dmem,
  input  logic                wren,
  input  logic [31:0]         data,
  input  logic [31:0]         q_ram,
  input  logic [NUM_BTNS-1:0] btn_raw,
  output logic [31:0]         q_dmem,
  output logic [31:0]         out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NUM_BTNS-1:0] btn_level
);

  localparam int          c_CW          = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] c_OUT_ADDR    = 32'(OUT_ADDR);
  localparam logic [31:0] c_STATUS_ADDR = 32'(STATUS_ADDR);
  localparam logic        c_EVENT_MODE  = (EVENT_MODE != 0);

  localparam logic [0:0] c_STABLE   = 1'b0;
  localparam logic [0:0] c_COUNTING = 1'b1;

  logic [NUM_BTNS-1:0] w_hit;
  logic [NUM_BTNS-1:0] w_level;
  logic [NUM_BTNS-1:0] w_event;

  generate
    for (genvar k = 0; k < NUM_BTNS; k++) begin : g_btn
      localparam logic [31:0] c_ADDR = 32'(BTN_BASE + k * BTN_STRIDE);

      logic [1:0]      r_sync;
      logic [0:0]      r_state;
      logic [0:0]      w_state_next;
      logic [c_CW-1:0] r_cnt;
      logic [c_CW-1:0] w_cnt_next;
      logic            w_load;
      logic            r_lvl;
      logic            r_evt;
      logic            w_lvl_next;
      logic            w_evt_next;

      assign w_hit[k] = !wren && (address_dmem == c_ADDR);

      always_ff @(posedge clock) begin
        if (reset) begin
          r_sync  <= 2'b00;
          r_state <= c_STABLE;
          r_cnt   <= '0;
          r_lvl   <= 1'b0;
          r_evt   <= 1'b0;
        end else begin
          r_sync  <= {r_sync[0], btn_raw[k]};
          r_state <= w_state_next;
          r_cnt   <= w_cnt_next;
          r_lvl   <= w_lvl_next;
          r_evt   <= w_evt_next;
        end
      end

      // In STABLE the effective count is zero, so a single-cycle debounce loads at once.
      always_comb begin
        w_state_next = c_STABLE;
        w_cnt_next   = '0;
        w_load       = 1'b0;
        if (r_sync[1] != r_lvl) begin
          if (r_state == c_COUNTING ? (r_cnt == c_CNT_LAST) : (DEBOUNCE_CYCLES == 1)) begin
            w_load = 1'b1;
          end else begin
            w_state_next = c_COUNTING;
            w_cnt_next   = (r_state == c_COUNTING) ? r_cnt + 1'b1 : c_CW'(1);
          end
        end
      end

      // A rising edge in the same cycle as a read clear wins over the clear.
      always_comb begin
        w_lvl_next = w_load ? r_sync[1] : r_lvl;
        w_evt_next = (w_load & r_sync[1]) | (r_evt & ~(w_hit[k] & c_EVENT_MODE));
      end

      assign w_level[k] = r_lvl;
      assign w_event[k] = r_evt;
    end
  endgenerate

  assign btn_level = w_level;

  logic        r_overflow;
  logic [31:0] r_out_data;
  logic        r_out_valid;
  logic        w_store;
  logic        w_ov_set;
  logic        w_status_hit;
  logic        w_btn_bit;
  logic [31:0] w_status;

  assign w_store      = wren && (address_dmem == c_OUT_ADDR);
  assign w_ov_set     = w_store && r_out_valid && !out_ready;
  assign w_status_hit = !wren && (address_dmem == c_STATUS_ADDR) && !(|w_hit);
  // Event field occupies bits 30:16 so that the overflow flag keeps bit 31.
  assign w_status     = {r_overflow, 15'(w_event), 16'(w_level)};

  always_comb begin
    w_btn_bit = 1'b0;
    for (int k = NUM_BTNS - 1; k >= 0; k--) begin
      if (w_hit[k]) w_btn_bit = c_EVENT_MODE ? w_event[k] : w_level[k];
    end
    if (|w_hit)            q_dmem = {31'b0, w_btn_bit};
    else if (w_status_hit) q_dmem = w_status;
    else                   q_dmem = q_ram;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_out_data  <= 32'b0;
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_store) begin
        if (!r_out_valid || out_ready) begin
          r_out_data  <= data;
          r_out_valid <= 1'b1;
        end
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      r_overflow <= w_ov_set | (r_overflow & ~w_status_hit);
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_mmio_button_io.sv
`default_nettype none
// ============================================================================
// tb_mmio_button_io : directed and randomized checks of mmio_button_io against
//                     a cycle-level behavioural model.
// Revision 1.0
// ============================================================================
module tb_mmio_button_io;

  localparam int NB     = 5;
  localparam int D      = 4;
  localparam int BASE   = 1000;
  localparam int STRIDE = 1000;
  localparam int OUTA   = 2000;
  localparam int STAT   = 7000;

  logic          clock = 1'b0;
  logic          reset;
  logic [31:0]   address_dmem;
  logic          wren;
  logic [31:0]   data;
  logic [31:0]   q_ram;
  logic [NB-1:0] btn_raw;
  logic [31:0]   q_dmem;
  logic [31:0]   out_data;
  logic          out_valid;
  logic          out_ready;
  logic [NB-1:0] btn_level;

  mmio_button_io #(
    .NUM_BTNS(NB), .BTN_BASE(BASE), .BTN_STRIDE(STRIDE), .OUT_ADDR(OUTA),
    .STATUS_ADDR(STAT), .DEBOUNCE_CYCLES(D), .EVENT_MODE(1)
  ) dut (
    .clock(clock), .reset(reset), .address_dmem(address_dmem), .wren(wren),
    .data(data), .q_ram(q_ram), .btn_raw(btn_raw), .q_dmem(q_dmem),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .btn_level(btn_level)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: raw inputs seen two edges late; a level flips after D
  // consecutive cycles of disagreement.
  logic [NB-1:0] m_d1 = '0, m_d2 = '0, m_level = '0, m_event = '0;
  int            m_run [NB] = '{default: 0};
  logic          m_ov = 1'b0, m_valid = 1'b0;
  logic [31:0]   m_data = 32'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_q();
    if (!wren) begin
      for (int k = 0; k < NB; k++)
        if (address_dmem == 32'(BASE + k * STRIDE)) return {31'b0, m_event[k]};
      if (address_dmem == 32'(STAT))
        return {m_ov, 10'b0, m_event, 11'b0, m_level};
    end
    return q_ram;
  endfunction

  function automatic void model_edge();
    logic [NB-1:0] set_v, clr_v, new_level;
    logic          any_hit;
    if (reset) begin
      m_d1 = '0; m_d2 = '0; m_level = '0; m_event = '0;
      for (int k = 0; k < NB; k++) m_run[k] = 0;
      m_ov = 1'b0; m_valid = 1'b0; m_data = 32'b0;
      return;
    end
    set_v = '0; clr_v = '0; new_level = m_level; any_hit = 1'b0;
    for (int k = 0; k < NB; k++) begin
      if (m_d2[k] != m_level[k]) begin
        m_run[k] = m_run[k] + 1;
        if (m_run[k] == D) begin
          new_level[k] = m_d2[k];
          m_run[k] = 0;
          if (m_d2[k]) set_v[k] = 1'b1;
        end
      end else begin
        m_run[k] = 0;
      end
      if (!wren && address_dmem == 32'(BASE + k * STRIDE)) begin
        clr_v[k] = 1'b1;
        any_hit = 1'b1;
      end
    end
    m_event = set_v | (m_event & ~clr_v);
    if (!wren && !any_hit && address_dmem == 32'(STAT)) m_ov = 1'b0;
    if (wren && address_dmem == 32'(OUTA)) begin
      if (!m_valid || out_ready) begin
        m_data = data;
        m_valid = 1'b1;
      end else begin
        m_ov = 1'b1;
      end
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    m_d2 = m_d1;
    m_d1 = btn_raw;
    m_level = new_level;
  endfunction

  task automatic tick();
    #2;
    chk("q_dmem", q_dmem, exp_q());
    model_edge();
    @(posedge clock);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", out_data, m_data);
    chk("btn_level", 32'(btn_level), 32'(m_level));
    @(negedge clock);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout observed=running required=finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; wren = 1'b0; address_dmem = 32'd0; data = 32'd0;
    q_ram = 32'd0; out_ready = 1'b0; btn_raw = '0;
    tick(); tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_level", 32'(btn_level), 32'd0);

    // Level latency: 2 sync cycles plus D counting cycles.
    reset = 1'b0; btn_raw = 5'b00100;
    repeat (5) tick();
    chk("lvl_cycle5", 32'(btn_level), 32'd0);
    tick();
    chk("lvl_cycle6", 32'(btn_level), 32'b00100);

    // Two-cycle glitch on button 0 is rejected.
    btn_raw = 5'b00101; tick(); tick();
    btn_raw = 5'b00100; repeat (8) tick();
    chk("glitch_lvl", 32'(btn_level), 32'b00100);
    address_dmem = 32'd7000; #1;
    chk("status_evt", q_dmem, 32'h0004_0004);
    tick(); address_dmem = 32'd0;

    // Sticky press on button 1, cleared by the read.
    btn_raw = 5'b00110; repeat (8) tick();
    address_dmem = 32'd2000; #1;
    chk("evt_read1", q_dmem, 32'd1);
    tick(); #1;
    chk("evt_read2", q_dmem, 32'd0);
    tick(); address_dmem = 32'd0;

    // Press whose level rises on the edge ending a read cycle survives the clear.
    btn_raw = 5'b00100; repeat (8) tick();
    btn_raw = 5'b00110; repeat (5) tick();
    address_dmem = 32'd2000; #1;
    chk("race_before", q_dmem, 32'd0);
    tick();
    chk("race_lvl", 32'(btn_level), 32'b00110);
    #1;
    chk("race_after", q_dmem, 32'd1);
    tick(); address_dmem = 32'd0;

    // Store into a full buffer is dropped and flags overflow.
    wren = 1'b1; address_dmem = 32'd2000; data = 32'h0000_CAFE; out_ready = 1'b0;
    tick();
    data = 32'h0000_BEEF; tick();
    wren = 1'b0; address_dmem = 32'd0;
    chk("ovf_data", out_data, 32'h0000_CAFE);
    chk("ovf_valid", 32'(out_valid), 32'd1);
    address_dmem = 32'd7000; #1;
    chk("ovf_status", q_dmem, 32'h8004_0006);
    tick(); #1;
    chk("ovf_cleared", q_dmem, 32'h0004_0006);
    tick(); address_dmem = 32'd0;

    // Store accepted while full because the consumer drains in the same cycle.
    wren = 1'b1; address_dmem = 32'd2000; data = 32'h0000_1234; out_ready = 1'b1;
    tick();
    wren = 1'b0; address_dmem = 32'd0;
    chk("refill_data", out_data, 32'h0000_1234);
    chk("refill_valid", 32'(out_valid), 32'd1);
    tick();
    chk("drain_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // RAM pass-through on a miss.
    address_dmem = 32'd500; q_ram = 32'h0000_0055; #1;
    chk("miss", q_dmem, 32'h0000_0055);
    tick();

    // Reset in the middle of a debounce and with a word buffered.
    wren = 1'b1; address_dmem = 32'd2000; data = 32'h0000_0077; tick();
    wren = 1'b0; address_dmem = 32'd0; q_ram = 32'd0;
    btn_raw = 5'b00011; repeat (3) tick();
    reset = 1'b1; tick();
    chk("rst2_valid", 32'(out_valid), 32'd0);
    chk("rst2_data", out_data, 32'd0);
    chk("rst2_level", 32'(btn_level), 32'd0);
    reset = 1'b0; address_dmem = 32'd7000; #1;
    chk("rst2_status", q_dmem, 32'd0);
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < NB; b++)
        if ($urandom_range(0, 9) == 0) btn_raw[b] = ~btn_raw[b];
      case ($urandom_range(0, 9))
        0:       address_dmem = 32'd0;
        1:       address_dmem = 32'd500;
        7:       address_dmem = 32'(STAT);
        8:       address_dmem = 32'(OUTA);
        9:       address_dmem = $urandom;
        default: address_dmem = 32'(BASE + $urandom_range(0, NB - 1) * STRIDE);
      endcase
      wren      = ($urandom_range(0, 2) == 0);
      data      = $urandom;
      q_ram     = $urandom;
      out_ready = $urandom_range(0, 1) == 1;
      reset     = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
